// File: rtl/fp_test_pkg.sv
// Shared types and constants for the FP adder operand sequencer.
package fp_test_pkg;

  // Sequencer states; the 3-bit codes are also shown on the LEDs.
  typedef enum logic [2:0] {
    ST_LOAD_A    = 3'd0,
    ST_LOAD_B    = 3'd1,
    ST_LOAD_CTRL = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT      = 3'd4,
    ST_SHOW      = 3'd5,
    ST_ERR       = 3'd6
  } state_e;

  // Control word layout on the switch bank.
  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 3;
  localparam int MODE_BIT = 3;
  localparam int RND_BIT  = 4;

  // Widest LED bank the error pattern helper can produce.
  localparam int LED_MAX_W = 64;

  // Alternating 1010... pattern of the given width, MSB set.
  function automatic logic [LED_MAX_W-1:0] err_led_pattern(input int width);
    logic [LED_MAX_W-1:0] pat;
    pat = '0;
    for (int i = 0; i < LED_MAX_W; i++) begin
      if ((i < width) && (((width - 1 - i) % 2) == 0)) begin
        pat[i] = 1'b1;
      end else begin
        pat[i] = 1'b0;
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/fp_test_sequencer_rise_detect.sv
// Registered rising-edge detector for a debounced level input.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  // Next value of the delayed copy is simply the current level.
  always_comb begin
    d_d = d;
  end

  // Delay register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/fp_test_sequencer.sv
// Board-level operand sequencer: loads operands from switches, issues one
// adder operation, waits for valid with timeout, pages result onto LEDs.
module fp_test_sequencer #(
  parameter int DATA_W  = 32,
  parameter int IO_W    = 16,
  parameter int FLAG_W  = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IO_W-1:0]   sw,
  input  logic              step,
  input  logic              rerun,
  output logic [IO_W-1:0]   led,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        op_code,
  output logic              mode_fp,
  output logic              round_mode,
  output logic              start,
  output logic              ready_out,
  input  logic [DATA_W-1:0] result,
  input  logic [FLAG_W-1:0] flags,
  input  logic              valid_in,
  output logic              busy,
  output logic              err
);
  import fp_test_pkg::*;

  localparam int NW = DATA_W / IO_W;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW = $clog2(NW + 1);
  localparam int TW = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic [WW-1:0]     widx_q, widx_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [2:0]        op_code_q, op_code_d;
  logic              mode_fp_q, mode_fp_d;
  logic              round_mode_q, round_mode_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [PW-1:0]     page_q, page_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic              step_rise_s, rerun_rise_s;
  logic [3:0]        widx_led_s;
  logic [IO_W-1:0]   led_s;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (step),
    .rise (step_rise_s)
  );

  rise_detect u_rerun_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (rerun),
    .rise (rerun_rise_s)
  );

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    widx_d       = widx_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    mode_fp_d    = mode_fp_q;
    round_mode_d = round_mode_q;
    result_d     = result_q;
    flags_d      = flags_q;
    page_d       = page_q;
    tcnt_d       = tcnt_q;
    case (state_q)
      ST_LOAD_A: begin
        if (step_rise_s) begin
          op_a_d[32'(widx_q)*IO_W +: IO_W] = sw;
          if (widx_q == WW'(NW - 1)) begin
            widx_d  = '0;
            state_d = ST_LOAD_B;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_B: begin
        if (step_rise_s) begin
          op_b_d[32'(widx_q)*IO_W +: IO_W] = sw;
          if (widx_q == WW'(NW - 1)) begin
            widx_d  = '0;
            state_d = ST_LOAD_CTRL;
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD_CTRL: begin
        if (step_rise_s) begin
          op_code_d    = sw[OPC_LSB +: OPC_W];
          mode_fp_d    = sw[MODE_BIT];
          round_mode_d = sw[RND_BIT];
          state_d      = ST_ISSUE;
        end else begin
          state_d = state_q;
        end
      end
      ST_ISSUE: begin
        tcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A valid arriving on the last allowed cycle still counts.
        if (valid_in) begin
          result_d = result;
          flags_d  = flags;
          page_d   = '0;
          state_d  = ST_SHOW;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_ERR;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (rerun_rise_s) begin
          page_d  = '0;
          state_d = ST_ISSUE;
        end else if (step_rise_s) begin
          if (page_q == PW'(NW)) begin
            page_d = '0;
          end else begin
            page_d = page_q + 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_ERR: begin
        if (rerun_rise_s) begin
          page_d  = '0;
          state_d = ST_ISSUE;
        end else if (step_rise_s) begin
          widx_d  = '0;
          state_d = ST_LOAD_A;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
        widx_d  = '0;
      end
    endcase
    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d == ST_ISSUE) || (state_d == ST_WAIT);
    err_d   = (state_d == ST_ERR);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD_A;
      widx_q       <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= 3'd0;
      mode_fp_q    <= 1'b0;
      round_mode_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= '0;
      flags_q      <= '0;
      page_q       <= '0;
      tcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      mode_fp_q    <= mode_fp_d;
      round_mode_q <= round_mode_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      page_q       <= page_d;
      tcnt_q       <= tcnt_d;
    end
  end

  // LED display decoded from registered state only.
  always_comb begin
    led_s = '0;
    if (32'(widx_q) > 32'd15) begin
      widx_led_s = 4'hF;
    end else begin
      widx_led_s = 4'(widx_q);
    end
    case (state_q)
      ST_LOAD_A, ST_LOAD_B, ST_LOAD_CTRL: begin
        led_s[2:0] = state_q;
        led_s[6:3] = widx_led_s;
      end
      ST_ISSUE, ST_WAIT: begin
        led_s[2:0] = state_q;
      end
      ST_SHOW: begin
        if (32'(page_q) < NW) begin
          led_s = result_q[32'(page_q)*IO_W +: IO_W];
        end else begin
          led_s[FLAG_W-1:0] = flags_q;
        end
      end
      ST_ERR: begin
        led_s = IO_W'(err_led_pattern(IO_W));
      end
      default: begin
        led_s[2:0] = state_q;
      end
    endcase
  end

  assign led        = led_s;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_code    = op_code_q;
  assign mode_fp    = mode_fp_q;
  assign round_mode = round_mode_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign err        = err_q;
  assign ready_out  = 1'b1;

endmodule
